// File: rtl/ifetch_pkg.sv
// ifetch_pkg
//   Shared types and constants for the instruction-fetch initiator:
//   datapath/instruction widths, the per-beat PC step, the fetch FSM
//   state encoding and a small alignment helper.
package ifetch_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] INSTR_STEP = 64'd4;

    typedef enum logic {
        RUN        = 1'b0,
        HALT_FAULT = 1'b1
    } state_e;

    // Instructions are 32-bit words, so a fetch PC must have its low two bits clear.
    function automatic logic is_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// ifetch_fifo
//   Small instruction buffer between the fetch bus and decode.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     flush             empties the buffer (pointers and count to zero)
//     push, push_pc,    write one {pc, instr} entry at the tail
//     push_instr
//     pop               retire the head entry
//     count             number of valid entries (0..DEPTH)
//     head_pc,          head entry, read combinationally from storage
//     head_instr
//   DEPTH must be a power of two and at least 2.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            push,
    input  logic [XLEN-1:0] push_pc,
    input  logic [ILEN-1:0] push_instr,
    input  logic            pop,
    output logic [CW-1:0]   count,
    output logic [XLEN-1:0] head_pc,
    output logic [ILEN-1:0] head_instr
);

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [ILEN-1:0] instr_mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push_ok;
    logic            pop_ok;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign push_ok = push && !flush && (count < CW'(DEPTH));
    assign pop_ok  = pop  && !flush && (count != '0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; an entry is only visible once count covers it.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            pc_mem[wr_ptr]    <= push_pc;
            instr_mem[wr_ptr] <= push_instr;
        end
    end

    assign head_pc    = pc_mem[rd_ptr];
    assign head_instr = instr_mem[rd_ptr];

endmodule

// File: rtl/ifetch_master.sv
// ifetch_master
//   Instruction-fetch bus initiator. Holds the fetch PC, issues sequential
//   32-bit word reads on the instruction bus, buffers returned words in
//   ifetch_fifo and hands them to decode over a valid/ready handshake.
//   Ports:
//     HCLK, HRESET      clock, synchronous active-high reset
//     HADDR             fetch address (the PC register)
//     HWRITE, HWDATA    tied to zero, reads only
//     HTRANS            fetch request active this cycle
//     HREADY, HRDATA    slave accept / read data (instruction in [31:0])
//     redir_valid,      redirect from execute (branch/jump/trap)
//     redir_pc
//     if_valid, if_ready, if_pc, if_instr   decode-side handshake and head entry
//     if_fault          misaligned-redirect fault indication
//   Build option: define IFETCH_ALIGN_CHECK_EN to halt on a misaligned redirect
//   (if_fault raised until an aligned redirect arrives). Without it, the low
//   two bits of redir_pc are dropped and if_fault stays 0.
module ifetch_master
    import ifetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VEC  = 64'h0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            HCLK,
    input  logic            HRESET,
    output logic [XLEN-1:0] HADDR,
    output logic            HWRITE,
    output logic [XLEN-1:0] HWDATA,
    output logic            HTRANS,
    input  logic            HREADY,
    input  logic [XLEN-1:0] HRDATA,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [ILEN-1:0] if_instr,
    output logic            if_fault
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e          state_q;
    state_e          state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [CW-1:0]   count;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_flush;
    logic            unused_bits;

    ifetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (HCLK),
        .rst        (HRESET),
        .flush      (fifo_flush),
        .push       (fifo_push),
        .push_pc    (pc_q),
        .push_instr (HRDATA[ILEN-1:0]),
        .pop        (fifo_pop),
        .count      (count),
        .head_pc    (if_pc),
        .head_instr (if_instr)
    );

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= RUN;
            pc_q    <= RESET_VEC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // HTRANS uses the registered count, so a full buffer blocks the request
    // even when decode pops in the same cycle.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fifo_flush = 1'b0;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        HTRANS     = !HRESET && (state_q == RUN) && (count < CW'(FIFO_DEPTH))
                     && !redir_valid;

        if (redir_valid) begin
            fifo_flush = 1'b1;
`ifdef IFETCH_ALIGN_CHECK_EN
            pc_d    = redir_pc;
            state_d = is_aligned(redir_pc) ? RUN : HALT_FAULT;
`else
            pc_d    = {redir_pc[XLEN-1:2], 2'b00};
            state_d = RUN;
`endif
        end else begin
            fifo_push = HTRANS && HREADY;
            fifo_pop  = if_valid && if_ready;
            if (fifo_push) begin
                pc_d = pc_q + INSTR_STEP;
            end
        end
    end

    assign HADDR    = pc_q;
    assign HWRITE   = 1'b0;
    assign HWDATA   = '0;
    assign if_valid = (count != '0);

`ifdef IFETCH_ALIGN_CHECK_EN
    assign if_fault    = (state_q == HALT_FAULT);
    assign unused_bits = ^HRDATA[XLEN-1:ILEN];
`else
    assign if_fault    = 1'b0;
    assign unused_bits = ^{HRDATA[XLEN-1:ILEN], redir_pc[1:0]};
`endif

endmodule

// File: tb/tb_ifetch_master.sv
// tb_ifetch_master
//   Directed table for the fetch/stall/redirect/wrap sequences, followed by
//   a randomised phase checked against a scoreboard queue of expected
//   {pc, instr} entries. Honours IFETCH_ALIGN_CHECK_EN like the design.
module tb_ifetch_master;

    localparam int D = 2;
    localparam logic [63:0] RV = 64'h0;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [63:0] HADDR;
    logic        HWRITE;
    logic [63:0] HWDATA;
    logic        HTRANS;
    logic        HREADY;
    logic [63:0] HRDATA;
    logic        redir_valid;
    logic [63:0] redir_pc;
    logic        if_valid;
    logic        if_ready;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        if_fault;

    int n_pass  = 0;
    int n_total = 0;

    ifetch_master #(.RESET_VEC(RV), .FIFO_DEPTH(D)) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HADDR       (HADDR),
        .HWRITE      (HWRITE),
        .HWDATA      (HWDATA),
        .HTRANS      (HTRANS),
        .HREADY      (HREADY),
        .HRDATA      (HRDATA),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .if_fault    (if_fault)
    );

    always #5 HCLK = ~HCLK;

    // Instruction ROM: word at 0 is 0x03020100; upper half is junk that must be ignored.
    function automatic logic [63:0] rom(input logic [63:0] a);
        logic [7:0]  b;
        logic [31:0] lo;
        b  = a[7:0];
        lo = {b + 8'd3, b + 8'd2, b + 8'd1, b} ^ {a[39:32], a[31:24], a[23:16], a[15:8]};
        return {~lo, lo};
    endfunction

    assign HRDATA = rom(HADDR);

    task automatic chk(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s [%0d]: got %h, want %h", name, idx, act, exp);
    endtask

    // ---------------- scoreboard model ----------------
    typedef struct { logic [63:0] pc; logic [31:0] instr; } ent_t;
    ent_t        m_q[$];
    logic [63:0] m_pc   = RV;
    logic        m_halt = 1'b0;

    task automatic apply(input logic rst, hr, ir, rv, input logic [63:0] rpc);
        @(negedge HCLK);
        HRESET      = rst;
        HREADY      = hr;
        if_ready    = ir;
        redir_valid = rv;
        redir_pc    = rpc;
        #1;
    endtask

    function automatic logic exp_htrans();
        return !HRESET && !m_halt && (m_q.size() < D) && !redir_valid;
    endfunction

    task automatic model_check(input int idx);
        chk("sb_htrans", idx, {63'd0, HTRANS}, {63'd0, exp_htrans()});
        if (!HRESET) begin
            chk("sb_haddr", idx, HADDR, m_pc);
            chk("sb_valid", idx, {63'd0, if_valid}, {63'd0, m_q.size() > 0});
            chk("sb_fault", idx, {63'd0, if_fault}, {63'd0, m_halt});
            if (m_q.size() > 0) begin
                chk("sb_pc", idx, if_pc, m_q[0].pc);
                chk("sb_instr", idx, {32'd0, if_instr}, {32'd0, m_q[0].instr});
            end
        end
    endtask

    task automatic model_update();
        logic [63:0] w;
        logic        do_push;
        if (HRESET) begin
            m_q.delete();
            m_pc   = RV;
            m_halt = 1'b0;
        end else if (redir_valid) begin
            m_q.delete();
`ifdef IFETCH_ALIGN_CHECK_EN
            m_pc   = redir_pc;
            m_halt = (redir_pc[1:0] != 2'b00);
`else
            m_pc   = redir_pc & ~64'd3;
`endif
        end else begin
            do_push = exp_htrans() && HREADY;
            if (m_q.size() > 0 && if_ready) void'(m_q.pop_front());
            if (do_push) begin
                w = rom(m_pc);
                m_q.push_back('{pc: m_pc, instr: w[31:0]});
                m_pc = m_pc + 64'd4;
            end
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        rst, hr, ir, rv;
        logic [63:0] rpc;
        logic        ht;
        logic [63:0] ha;
        logic        v;
        logic [63:0] pc;
        logic        flt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, hr, ir, rv, input logic [63:0] rpc,
                                input logic ht, input logic [63:0] ha, input logic v,
                                input logic [63:0] pc, input logic flt);
        vec_t r;
        r.rst = rst; r.hr = hr; r.ir = ir; r.rv = rv; r.rpc = rpc;
        r.ht = ht; r.ha = ha; r.v = v; r.pc = pc; r.flt = flt;
        return r;
    endfunction

    localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

    initial begin
        logic [63:0] w;
        HRESET = 1'b1; HREADY = 1'b1; if_ready = 1'b1; redir_valid = 1'b0; redir_pc = '0;

        //             rst hr ir rv rpc      ht ha      v  pc     flt
        // sequential fetch from reset
        vecs.push_back(mk(1, 1, 1, 0, 0,     0, 0,      0, 0,     0));
        vecs.push_back(mk(1, 1, 1, 0, 0,     0, 0,      0, 0,     0));
        vecs.push_back(mk(0, 1, 1, 0, 0,     1, 0,      0, 0,     0));
        vecs.push_back(mk(0, 1, 1, 0, 0,     1, 4,      1, 0,     0));
        vecs.push_back(mk(0, 1, 1, 0, 0,     1, 8,      1, 4,     0));
        // decode back-pressure fills the buffer
        vecs.push_back(mk(1, 1, 0, 0, 0,     0, 0,      0, 0,     0));
        vecs.push_back(mk(0, 1, 0, 0, 0,     1, 0,      0, 0,     0));
        vecs.push_back(mk(0, 1, 0, 0, 0,     1, 4,      1, 0,     0));
        vecs.push_back(mk(0, 1, 0, 0, 0,     0, 8,      1, 0,     0));
        vecs.push_back(mk(0, 1, 0, 0, 0,     0, 8,      1, 0,     0));
        vecs.push_back(mk(0, 1, 1, 0, 0,     0, 8,      1, 0,     0));
        vecs.push_back(mk(0, 1, 1, 0, 0,     1, 8,      1, 4,     0));
        vecs.push_back(mk(0, 1, 1, 0, 0,     1, 12,     1, 8,     0));
        // bus wait states at HADDR=4
        vecs.push_back(mk(1, 1, 0, 0, 0,     0, 0,      0, 0,     0));
        vecs.push_back(mk(0, 1, 0, 0, 0,     1, 0,      0, 0,     0));
        vecs.push_back(mk(0, 0, 0, 0, 0,     1, 4,      1, 0,     0));
        vecs.push_back(mk(0, 0, 0, 0, 0,     1, 4,      1, 0,     0));
        vecs.push_back(mk(0, 0, 0, 0, 0,     1, 4,      1, 0,     0));
        vecs.push_back(mk(0, 1, 0, 0, 0,     1, 4,      1, 0,     0));
        vecs.push_back(mk(0, 1, 1, 0, 0,     0, 8,      1, 0,     0));
        vecs.push_back(mk(0, 1, 1, 0, 0,     1, 8,      1, 4,     0));
        // redirect with two entries buffered
        vecs.push_back(mk(0, 1, 0, 0, 0,     1, 12,     1, 8,     0));
        vecs.push_back(mk(0, 1, 1, 1, 'h40,  0, 16,     1, 8,     0));
        vecs.push_back(mk(0, 1, 1, 0, 0,     1, 'h40,   0, 0,     0));
        vecs.push_back(mk(0, 1, 1, 0, 0,     1, 'h44,   1, 'h40,  0));
        // PC wrap at the top of the address space
        vecs.push_back(mk(0, 1, 1, 1, TOP,   0, 'h48,   1, 'h44,  0));
        vecs.push_back(mk(0, 1, 1, 0, 0,     1, TOP,    0, 0,     0));
        vecs.push_back(mk(0, 1, 1, 0, 0,     1, 0,      1, TOP,   0));
        // misaligned redirect, then aligned redirect
        vecs.push_back(mk(0, 1, 1, 1, 'h42,  0, 4,      1, 0,     0));
`ifdef IFETCH_ALIGN_CHECK_EN
        vecs.push_back(mk(0, 1, 1, 0, 0,     0, 'h42,   0, 0,     1));
        vecs.push_back(mk(0, 1, 1, 1, 'h80,  0, 'h42,   0, 0,     1));
`else
        vecs.push_back(mk(0, 1, 1, 0, 0,     1, 'h40,   0, 0,     0));
        vecs.push_back(mk(0, 1, 1, 1, 'h80,  0, 'h44,   1, 'h40,  0));
`endif
        vecs.push_back(mk(0, 1, 1, 0, 0,     1, 'h80,   0, 0,     0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].hr, vecs[i].ir, vecs[i].rv, vecs[i].rpc);
            chk("tbl_htrans", i, {63'd0, HTRANS}, {63'd0, vecs[i].ht});
            if (!vecs[i].rst) begin
                chk("tbl_haddr", i, HADDR, vecs[i].ha);
                chk("tbl_valid", i, {63'd0, if_valid}, {63'd0, vecs[i].v});
                chk("tbl_fault", i, {63'd0, if_fault}, {63'd0, vecs[i].flt});
                if (vecs[i].v) begin
                    w = rom(vecs[i].pc);
                    chk("tbl_pc", i, if_pc, vecs[i].pc);
                    chk("tbl_instr", i, {32'd0, if_instr}, {32'd0, w[31:0]});
                end
                chk("tbl_hwrite", i, {63'd0, HWRITE}, 64'd0);
                chk("tbl_hwdata", i, HWDATA, 64'd0);
            end
            model_check(i);
            model_update();
        end

        // ---------------- randomised phase ----------------
        for (int i = 0; i < 600; i++) begin
            logic        rst, hr, ir, rv;
            logic [63:0] rpc;
            rst = ($urandom_range(0, 99) < 1);
            hr  = ($urandom_range(0, 99) < 75);
            ir  = ($urandom_range(0, 99) < 60);
            rv  = ($urandom_range(0, 99) < 6);
            rpc = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) rpc = TOP - 64'(4 * $urandom_range(0, 2));
            apply(rst, hr, ir, rv, rpc);
            model_check(1000 + i);
            model_update();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
